// File: rtl/spi_master.sv
// SPI mode-0 master: one DATA_W-bit full-duplex transfer per accepted start, MSB first.
// Latency: start accepted in cycle 0 -> cs_n low from cycle 1, rx_valid at cycle 1+(2*DATA_W+2)*CLK_DIV.
// Backpressure: start is only sampled in IDLE; requests in any other state are dropped, never queued.
//
// Ports:
//   CLK, rst          system clock (rising edge), asynchronous active-high reset
//   start, tx_data    transfer request and the word to send (latched on acceptance)
//   busy              high from the cycle after acceptance through the DONE cycle
//   rx_data, rx_valid last received word and its one-cycle update strobe
//   sck, mosi, miso   SPI clock (CPOL=0, CPHA=0) and serial data lines
//   cs_n              active-low chip select
// DATA_W must be at least 2 and CLK_DIV must be at least 2.
module spi_master #(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = 8
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              sck,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n
);

    localparam int DIV_W  = $clog2(CLK_DIV) + 1;
    localparam int HALF_W = $clog2(2 * DATA_W) + 1;

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [HALF_W-1:0] HALF_LAST  = HALF_W'(2 * DATA_W);
    localparam logic [HALF_W-1:0] FINAL_FALL = HALF_W'(2 * DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        TRANSFER,
        HOLD,
        DONE
    } state_t;

    state_t              state;
    logic [DIV_W-1:0]    div_cnt;   // cycles left in the current half-period / phase
    logic [HALF_W-1:0]   half_idx;  // 1-based index of the half-period in progress
    logic [DATA_W-2:0]   tx_sr;     // bits still to be driven; MSB goes out directly
    logic [DATA_W-1:0]   rx_sr;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            div_cnt  <= '0;
            half_idx <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            busy     <= 1'b0;
            sck      <= 1'b0;
            mosi     <= 1'b0;
            cs_n     <= 1'b1;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= SETUP;
                        div_cnt <= DIV_LAST;
                        tx_sr   <= tx_data[DATA_W-2:0];
                        mosi    <= tx_data[DATA_W-1];
                        cs_n    <= 1'b0;
                        busy    <= 1'b1;
                    end
                end

                SETUP: begin
                    if (div_cnt == '0) begin
                        // First rising sck edge: slave has seen the MSB for a full half-period.
                        state    <= TRANSFER;
                        div_cnt  <= DIV_LAST;
                        half_idx <= HALF_W'(1);
                        sck      <= 1'b1;
                        rx_sr    <= {rx_sr[DATA_W-2:0], miso};
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end

                TRANSFER: begin
                    if (div_cnt == '0) begin
                        div_cnt <= DIV_LAST;
                        if (half_idx == HALF_LAST) begin
                            state    <= HOLD;
                            half_idx <= '0;
                            sck      <= 1'b0;
                        end else begin
                            half_idx <= half_idx + 1'b1;
                            sck      <= ~sck;
                            if (!sck) begin
                                rx_sr <= {rx_sr[DATA_W-2:0], miso};
                            end else if (half_idx != FINAL_FALL) begin
                                // Falling edge: present the next bit. The last falling
                                // edge has nothing left to send, so mosi keeps its value.
                                mosi  <= tx_sr[DATA_W-2];
                                tx_sr <= tx_sr << 1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end

                HOLD: begin
                    if (div_cnt == '0) begin
                        state    <= DONE;
                        cs_n     <= 1'b1;
                        mosi     <= 1'b0;
                        rx_data  <= rx_sr;
                        rx_valid <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end

                DONE: begin
                    // busy drops on entry to IDLE so a held start restarts one cycle later.
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    sck   <= 1'b0;
                    mosi  <= 1'b0;
                    cs_n  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: default build (CLK_DIV=4) plus a CLK_DIV=2 build.
// Expected receive words are queued when a transfer is launched and popped when rx_valid fires.
// Per-cycle output history is recorded so each scenario can check timing against cycle numbers.
module tb_spi_master;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    // Default build (CLK_DIV=4, DATA_W=8)
    logic       start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       busy, rx_valid, sck, mosi, cs_n, miso;
    logic [7:0] rx_data;
    int         miso_mode = 0;  // 0: loopback, 1: tied high, 2: tied low

    // CLK_DIV=2 build, always looped back
    logic       start2 = 1'b0;
    logic [7:0] tx2 = 8'h00;
    logic       busy2, rv2, sck2, mosi2, cs2;
    logic [7:0] rx2;

    assign miso = (miso_mode == 0) ? mosi : (miso_mode == 1);

    always #5 clk = ~clk;

    spi_master #(.CLK_DIV(4), .DATA_W(8)) dut (
        .CLK(clk), .rst(rst), .start(start), .tx_data(tx_data), .busy(busy),
        .rx_data(rx_data), .rx_valid(rx_valid), .sck(sck), .mosi(mosi),
        .miso(miso), .cs_n(cs_n)
    );

    spi_master #(.CLK_DIV(2), .DATA_W(8)) dut2 (
        .CLK(clk), .rst(rst), .start(start2), .tx_data(tx2), .busy(busy2),
        .rx_data(rx2), .rx_valid(rv2), .sck(sck2), .mosi(mosi2),
        .miso(mosi2), .cs_n(cs2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    logic sck_h[0:199], cs_h[0:199], rv_h[0:199], busy_h[0:199], mosi_h[0:199];

    // Records outputs of one DUT for cycles 0..ncyc (cycle 0 = cycle start is sampled)
    // and drives its start/tx_data: start high for cycles 0..hold_until, tx_data = tx in
    // cycle 0, nxt while start is held, random afterwards.
    task automatic run(input bit sel, input logic [7:0] tx, input int ncyc,
                       input int hold_until, input logic [7:0] nxt,
                       input int p1, input int p2);
        for (int k = 0; k <= ncyc; k++) begin
            @(negedge clk);
            if (!sel) begin
                sck_h[k] = sck; cs_h[k] = cs_n; rv_h[k] = rx_valid;
                busy_h[k] = busy; mosi_h[k] = mosi;
                if (rx_valid) got_q.push_back(rx_data);
                start   = (k <= hold_until) || (k == p1) || (k == p2);
                tx_data = (k == 0) ? tx : ((k <= hold_until) ? nxt : 8'($urandom));
            end else begin
                sck_h[k] = sck2; cs_h[k] = cs2; rv_h[k] = rv2;
                busy_h[k] = busy2; mosi_h[k] = mosi2;
                if (rv2) got_q.push_back(rx2);
                start2 = (k <= hold_until) || (k == p1) || (k == p2);
                tx2    = (k == 0) ? tx : ((k <= hold_until) ? nxt : 8'($urandom));
            end
        end
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic test_reset();
        start = 1'b1;
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({cs_n, sck, mosi, busy, rx_valid} !== 5'b10000) begin
            n_bad++;
            $display("FAIL reset_ctrl got cs_n,sck,mosi,busy,rv=%b want 10000",
                     {cs_n, sck, mosi, busy, rx_valid});
        end
        n_cmp++;
        if (rx_data !== 8'h00) begin
            n_bad++; $display("FAIL reset_rx_data got %h want 00", rx_data);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({cs_n, sck, busy} !== 3'b100) begin
            n_bad++; $display("FAIL reset_hold got cs_n,sck,busy=%b want 100", {cs_n, sck, busy});
        end
        start = 1'b0;
        rst   = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_loopback_a5();
        int rises, bad_cs;
        logic [7:0] bits;
        miso_mode = 0;
        exp_q.push_back(8'hA5);
        run(0, 8'hA5, 80, 0, 8'h00, -1, -1);
        rises = 0; bits = 8'h00; bad_cs = 0;
        for (int k = 1; k <= 80; k++) begin
            if (sck_h[k] && !sck_h[k-1]) begin rises++; bits = {bits[6:0], mosi_h[k]}; end
            if (cs_h[k] && sck_h[k]) bad_cs++;
        end
        n_cmp++;
        if ({cs_h[0], cs_h[1]} !== 2'b10) begin
            n_bad++; $display("FAIL a5_cs_start got cyc0,cyc1=%b want 10", {cs_h[0], cs_h[1]});
        end
        n_cmp++;
        if ({busy_h[0], busy_h[1]} !== 2'b01) begin
            n_bad++; $display("FAIL a5_busy_start got cyc0,cyc1=%b want 01", {busy_h[0], busy_h[1]});
        end
        n_cmp++;
        if (bits !== 8'hA5) begin
            n_bad++; $display("FAIL a5_mosi_bits got %h want a5", bits);
        end
        n_cmp++;
        if (rises != 8) begin
            n_bad++; $display("FAIL a5_sck_rises got %0d want 8", rises);
        end
        n_cmp++;
        if (bad_cs != 0) begin
            n_bad++; $display("FAIL a5_sck_while_cs_high got %0d cycles want 0", bad_cs);
        end
        n_cmp++;
        if ({rv_h[72], rv_h[73], rv_h[74]} !== 3'b010) begin
            n_bad++; $display("FAIL a5_rv_timing got cyc72..74=%b want 010", {rv_h[72], rv_h[73], rv_h[74]});
        end
        n_cmp++;
        if ({busy_h[73], busy_h[74], cs_h[73]} !== 3'b101) begin
            n_bad++; $display("FAIL a5_done got busy73,busy74,cs73=%b want 101",
                              {busy_h[73], busy_h[74], cs_h[73]});
        end
        n_cmp++;
        if (got_q.size() != 1) begin
            n_bad++; $display("FAIL a5_rv_count got %0d want 1", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL a5_rx_data got %h want %h", g, e); end
        end
        n_cmp++;
        if (rx_data !== 8'hA5) begin
            n_bad++; $display("FAIL a5_rx_hold got %h want a5", rx_data);
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_tied_miso();
        int ones;
        // miso high, sending zeros
        miso_mode = 1;
        exp_q.push_back(8'hFF);
        run(0, 8'h00, 80, 0, 8'h00, -1, -1);
        ones = 0;
        for (int k = 0; k <= 80; k++) if (mosi_h[k]) ones++;
        n_cmp++;
        if (ones != 0) begin n_bad++; $display("FAIL tied1_mosi_const got %0d high cycles want 0", ones); end
        // miso low, sending ones
        miso_mode = 2;
        exp_q.push_back(8'h00);
        run(0, 8'hFF, 80, 0, 8'h00, -1, -1);
        n_cmp++;
        if (got_q.size() != 2) begin n_bad++; $display("FAIL tied_rv_count got %0d want 2", got_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL tied_rx_data got %h want %h", g, e); end
        end
        got_q.delete(); exp_q.delete();
        miso_mode = 0;
    endtask

    task automatic test_start_ignored();
        int rises, cs_low_late;
        miso_mode = 0;
        exp_q.push_back(8'h3A);
        run(0, 8'h3A, 160, 0, 8'h00, 10, 40);
        rises = 0; cs_low_late = 0;
        for (int k = 1; k <= 160; k++) begin
            if (sck_h[k] && !sck_h[k-1]) rises++;
            if (k >= 73 && !cs_h[k]) cs_low_late++;
        end
        n_cmp++;
        if (rises != 8) begin n_bad++; $display("FAIL ign_sck_rises got %0d want 8", rises); end
        n_cmp++;
        if (cs_low_late != 0) begin n_bad++; $display("FAIL ign_second_xfer got %0d cs low cycles want 0", cs_low_late); end
        n_cmp++;
        if (got_q.size() != 1) begin n_bad++; $display("FAIL ign_rv_count got %0d want 1", got_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL ign_rx_data got %h want %h", g, e); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int rv_seen;
        miso_mode = 0;
        run(0, 8'h96, 29, 0, 8'h00, -1, -1);
        @(negedge clk);  // cycle 30, inside an sck-high half-period
        n_cmp++;
        if ({cs_n, sck} !== 2'b01) begin n_bad++; $display("FAIL mid_pre_reset got cs_n,sck=%b want 01", {cs_n, sck}); end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({cs_n, sck, mosi, busy, rx_valid} !== 5'b10000) begin
            n_bad++; $display("FAIL mid_async_reset got cs_n,sck,mosi,busy,rv=%b want 10000",
                              {cs_n, sck, mosi, busy, rx_valid});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rv_seen = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (rx_valid || !cs_n) rv_seen++;
        end
        n_cmp++;
        if (rv_seen != 0) begin n_bad++; $display("FAIL mid_abort got %0d active cycles want 0", rv_seen); end
        n_cmp++;
        if (rx_data !== 8'h00) begin n_bad++; $display("FAIL mid_rx_cleared got %h want 00", rx_data); end
        exp_q.push_back(8'h3C);
        run(0, 8'h3C, 80, 0, 8'h00, -1, -1);
        n_cmp++;
        if (rv_h[73] !== 1'b1 || got_q.size() != 1) begin
            n_bad++; $display("FAIL mid_next_xfer got rv73=%b count=%0d want 1 and 1", rv_h[73], got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL mid_rx_data got %h want %h", g, e); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int hi_run;
        miso_mode = 0;
        exp_q.push_back(8'h81);
        exp_q.push_back(8'h7E);
        run(0, 8'h81, 150, 80, 8'h7E, -1, -1);
        hi_run = 0;
        for (int k = 2; k <= 146; k++) if (cs_h[k]) hi_run++;
        n_cmp++;
        if ({cs_h[72], cs_h[73], cs_h[74], cs_h[75]} !== 4'b0110) begin
            n_bad++; $display("FAIL b2b_gap got cs72..75=%b want 0110", {cs_h[72], cs_h[73], cs_h[74], cs_h[75]});
        end
        n_cmp++;
        if (hi_run != 2) begin n_bad++; $display("FAIL b2b_cs_high_cycles got %0d want 2", hi_run); end
        n_cmp++;
        if ({busy_h[74], busy_h[75], rv_h[147]} !== 3'b011) begin
            n_bad++; $display("FAIL b2b_restart got busy74,busy75,rv147=%b want 011",
                              {busy_h[74], busy_h[75], rv_h[147]});
        end
        n_cmp++;
        if (got_q.size() != 2) begin n_bad++; $display("FAIL b2b_rv_count got %0d want 2", got_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL b2b_rx_data got %h want %h", g, e); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_div2();
        int bad_lvl;
        exp_q.push_back(8'h5A);
        run(1, 8'h5A, 45, 0, 8'h00, -1, -1);
        bad_lvl = 0;
        if (sck_h[1] || sck_h[2] || sck_h[35] || sck_h[36]) bad_lvl++;
        for (int i = 0; i < 32; i++) if (sck_h[3+i] !== (((i / 2) % 2) == 0)) bad_lvl++;
        n_cmp++;
        if (bad_lvl != 0) begin n_bad++; $display("FAIL div2_sck_levels got %0d bad cycles want 0", bad_lvl); end
        n_cmp++;
        if ({cs_h[0], cs_h[1], rv_h[36], rv_h[37], rv_h[38]} !== 5'b10010) begin
            n_bad++; $display("FAIL div2_timing got cs0,cs1,rv36..38=%b want 10010",
                              {cs_h[0], cs_h[1], rv_h[36], rv_h[37], rv_h[38]});
        end
        n_cmp++;
        if (got_q.size() != 1) begin n_bad++; $display("FAIL div2_rv_count got %0d want 1", got_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL div2_rx_data got %h want %h", g, e); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_loopback_a5();
        test_tied_miso();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_div2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, SCK half-period in CLK cycles (legal range 2..255).
REQ-002 SHALL have parameter DATA_W, default 8, bits per transfer.
REQ-003 SHALL have port CLK  input  1  single system clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request a transfer; sampled only in IDLE.
REQ-006 SHALL have port tx_data  input  DATA_W  byte to send, latched when start is accepted.
REQ-007 SHALL have port busy  output  1  high from the cycle after acceptance through the DONE cycle.
REQ-008 SHALL have port rx_data  output  DATA_W  last received word, held until the next DONE.
REQ-009 SHALL have port rx_valid  output  1  one-cycle pulse marking new rx_data.
REQ-010 SHALL have port sck  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-011 SHALL have port mosi  output  1  serial data out, MSB first.
REQ-012 SHALL have port miso  input  1  serial data in, MSB first.
REQ-013 SHALL have port cs_n  output  1  active-low chip select.

Function
REQ-014 SHALL implement states IDLE, SETUP, TRANSFER, HOLD and DONE.
REQ-015 IDLE: cs_n=1, sck=0, mosi=0, busy=0; start=1 -> latch tx_data, go to SETUP.
REQ-016 SETUP: cs_n=0, sck=0, mosi=tx_data[DATA_W-1]; lasts exactly CLK_DIV cycles, then TRANSFER.
REQ-017 TRANSFER: 2*DATA_W half-periods of CLK_DIV cycles each; sck=1 in odd half-periods, 0 in even.
REQ-018 The cycle sck goes 0->1, the block SHALL shift miso into the receive register LSB (sample, no metastability sync required).
REQ-019 The cycle sck goes 1->0, mosi SHALL advance to the next lower bit; after the final falling edge mosi holds its last value.
REQ-020 After half-period 2*DATA_W, the block SHALL enter HOLD: cs_n=0, sck=0 for CLK_DIV cycles, then DONE.
REQ-021 DONE (one cycle): cs_n=1, rx_data updated, rx_valid=1, busy=1; next state IDLE.
REQ-022 Latency: start accepted at cycle 0 -> cs_n low from cycle 1; rx_valid at cycle 1+(2*DATA_W+2)*CLK_DIV (73 for defaults).
REQ-023 Exactly DATA_W sck rising edges SHALL occur per transfer; sck SHALL never toggle while cs_n=1.
REQ-024 start asserted in any state other than IDLE SHALL be ignored and SHALL NOT be queued.
REQ-025 tx_data changes after acceptance SHALL NOT affect the transfer in progress.
REQ-026 Back-to-back: start held high SHALL begin the next transfer from the first IDLE cycle, giving cs_n high for exactly 2 cycles (DONE + IDLE).
REQ-027 Half-period counter SHALL be $clog2(CLK_DIV)+1 bits, reloaded at each state/half-period boundary; bit counter SHALL wrap only via state exit.

Reset
REQ-028 rst=1 SHALL immediately (asynchronously) force IDLE, cs_n=1, sck=0, mosi=0, busy=0, rx_valid=0, rx_data=0.
REQ-029 Reset mid-transfer SHALL abort without an rx_valid pulse; first start after rst deasserts SHALL run a complete normal transfer.

Verification
REQ-030 Loopback miso=mosi, CLK_DIV=4, start with tx_data=0xA5 -> mosi bits 1,0,1,0,0,1,0,1; rx_data=0xA5, rx_valid single pulse at cycle 73, busy low at 74.
REQ-031 miso tied 1, tx_data=0x00 -> mosi constant 0, rx_data=0xFF; miso tied 0, tx_data=0xFF -> rx_data=0x00.
REQ-032 start pulsed again at cycles 10 and 40 of a transfer -> only one transfer, one rx_valid, exactly 8 sck rising edges.
REQ-033 rst asserted at cycle 30 of a transfer -> cs_n=1, sck=0 same cycle, no rx_valid; next 0x3C transfer loops back 0x3C.
REQ-034 start held high for two transfers (0x81 then 0x7E) -> cs_n high exactly 2 cycles between them, rx_data 0x81 then 0x7E.
REQ-035 CLK_DIV=2 build, loopback 0x5A -> rx_valid at cycle 37, each sck level lasting exactly 2 cycles.
